// File: rtl/mirage_gpio_bank.sv
// Memory-mapped GPIO bank for the Mirage SoC: per-port OUT/DIR/IN/PEND/IE registers,
// set/clear/toggle aliases, synchronised inputs and rising-edge interrupt capture.
module mirage_gpio_bank #(
   parameter int                    PORT_COUNT = 2,
   parameter int                    PORT_WIDTH = 8,
   parameter int                    DATA_WIDTH = 16,
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'h0200
) (
   input  logic                             aClock,
   input  logic                             aReset,
   input  logic [ADDR_WIDTH-1:0]            aAddress,
   input  logic [DATA_WIDTH-1:0]            aWriteData,
   input  logic                             aWrite,
   input  logic                             aRead,
   output logic                             anOutSelect,
   output logic [DATA_WIDTH-1:0]            anOutReadData,
   output logic                             anOutReadValid,
   input  logic [PORT_COUNT*PORT_WIDTH-1:0] aPinIn,
   output logic [PORT_COUNT*PORT_WIDTH-1:0] anOutPinOut,
   output logic [PORT_COUNT*PORT_WIDTH-1:0] anOutPinOe,
   output logic                             anOutIrq
);

   localparam int                    PORT_BITS = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;
   localparam logic [ADDR_WIDTH-1:0] SPAN      = ADDR_WIDTH'(8 * PORT_COUNT);

   typedef enum logic [2:0] {
      REG_OUT  = 3'd0,
      REG_DIR  = 3'd1,
      REG_IN   = 3'd2,
      REG_PEND = 3'd3,
      REG_IE   = 3'd4,
      REG_SET  = 3'd5,
      REG_CLR  = 3'd6,
      REG_TGL  = 3'd7
   } regSel_e;

   logic [ADDR_WIDTH-1:0] offset;
   logic                  hit;
   logic [PORT_BITS-1:0]  portSel;
   regSel_e               regSel;
   logic [PORT_WIDTH-1:0] wData;
   logic                  unusedBits;

   // Addresses below the base wrap to a large offset, so one unsigned compare covers both bounds.
   assign offset      = aAddress - BASE_ADDR;
   assign hit         = offset < SPAN;
   assign portSel     = offset[3 +: PORT_BITS];
   assign regSel      = regSel_e'(offset[2:0]);
   assign wData       = aWriteData[PORT_WIDTH-1:0];
   assign unusedBits  = ^aWriteData;
   assign anOutSelect = hit;

   logic [PORT_WIDTH-1:0] outReg   [PORT_COUNT];
   logic [PORT_WIDTH-1:0] dirReg   [PORT_COUNT];
   logic [PORT_WIDTH-1:0] pendReg  [PORT_COUNT];
   logic [PORT_WIDTH-1:0] ieReg    [PORT_COUNT];
   logic [PORT_WIDTH-1:0] syncMeta [PORT_COUNT];
   logic [PORT_WIDTH-1:0] inReg    [PORT_COUNT];
   logic [PORT_WIDTH-1:0] inPrev   [PORT_COUNT];
   logic [1:0]            armCount;
   logic                  armed;

   logic [PORT_WIDTH-1:0] rise     [PORT_COUNT];
   logic [PORT_WIDTH-1:0] pendClr  [PORT_COUNT];
   logic [PORT_WIDTH-1:0] outNext  [PORT_COUNT];
   logic [PORT_WIDTH-1:0] dirNext  [PORT_COUNT];
   logic [PORT_WIDTH-1:0] ieNext   [PORT_COUNT];
   logic [DATA_WIDTH-1:0] readMux;
   logic                  irqNext;

   assign armed = (armCount == 2'd3);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      readMux = '0;
      irqNext = 1'b0;
      for (int p = 0; p < PORT_COUNT; p++) begin
         rise[p]    = armed ? (inReg[p] & ~inPrev[p] & ~dirReg[p]) : '0;
         pendClr[p] = '0;
         outNext[p] = outReg[p];
         dirNext[p] = dirReg[p];
         ieNext[p]  = ieReg[p];
         irqNext    = irqNext | (|(pendReg[p] & ieReg[p]));

         if (hit && portSel == PORT_BITS'(p)) begin
            if (aWrite) begin
               case (regSel)
                  REG_OUT:  outNext[p] = wData;
                  REG_DIR:  dirNext[p] = wData;
                  REG_PEND: pendClr[p] = wData;
                  REG_IE:   ieNext[p]  = wData;
                  REG_SET:  outNext[p] = outReg[p] | wData;
                  REG_CLR:  outNext[p] = outReg[p] & ~wData;
                  REG_TGL:  outNext[p] = outReg[p] ^ wData;
                  default:  ;
               endcase
            end
            // Reads see the registers as they stand before this edge's write.
            case (regSel)
               REG_OUT:  readMux[PORT_WIDTH-1:0] = outReg[p];
               REG_DIR:  readMux[PORT_WIDTH-1:0] = dirReg[p];
               REG_IN:   readMux[PORT_WIDTH-1:0] = inReg[p];
               REG_PEND: readMux[PORT_WIDTH-1:0] = pendReg[p];
               REG_IE:   readMux[PORT_WIDTH-1:0] = ieReg[p];
               default:  ;
            endcase
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge aClock) begin
      if (aReset) begin
         // NOTE: the per-port arrays are real flops, not RAM, so each one is cleared explicitly.
         for (int p = 0; p < PORT_COUNT; p++) begin
            outReg[p]   <= '0;
            dirReg[p]   <= '0;
            pendReg[p]  <= '0;
            ieReg[p]    <= '0;
            syncMeta[p] <= '0;
            inReg[p]    <= '0;
            inPrev[p]   <= '0;
         end
         armCount       <= 2'd0;
         anOutReadData  <= '0;
         anOutReadValid <= 1'b0;
         anOutIrq       <= 1'b0;
      end else begin
         for (int p = 0; p < PORT_COUNT; p++) begin
            outReg[p]   <= outNext[p];
            dirReg[p]   <= dirNext[p];
            ieReg[p]    <= ieNext[p];
            syncMeta[p] <= aPinIn[p*PORT_WIDTH +: PORT_WIDTH];
            inReg[p]    <= syncMeta[p];
            inPrev[p]   <= inReg[p];
            // A new rise is OR-ed in after the clear, so set wins on a collision.
            pendReg[p]  <= (pendReg[p] & ~pendClr[p]) | rise[p];
         end
         if (!armed) begin
            armCount <= armCount + 2'd1;
         end
         anOutReadValid <= hit && aRead;
         anOutReadData  <= (hit && aRead) ? readMux : '0;
         anOutIrq       <= irqNext;
      end
   end

   for (genvar p = 0; p < PORT_COUNT; p++) begin : genPins
      assign anOutPinOut[p*PORT_WIDTH +: PORT_WIDTH] = outReg[p];
      assign anOutPinOe[p*PORT_WIDTH +: PORT_WIDTH]  = dirReg[p];
   end

endmodule

// File: tb/tb_mirage_gpio_bank.sv
// Self-checking bench for mirage_gpio_bank: directed register-map scenarios with literal
// expectations, then randomized bus/pin/reset traffic compared every cycle to a register-level model.
module tb_mirage_gpio_bank;

   localparam int NP   = 2;
   localparam int PW   = 8;
   localparam int BASE = 'h0200;

   logic        aClock = 1'b0;
   logic        aReset = 1'b1;
   logic [15:0] aAddress = '0;
   logic [15:0] aWriteData = '0;
   logic        aWrite = 1'b0;
   logic        aRead = 1'b0;
   logic        anOutSelect;
   logic [15:0] anOutReadData;
   logic        anOutReadValid;
   logic [15:0] aPinIn = '0;
   logic [15:0] anOutPinOut;
   logic [15:0] anOutPinOe;
   logic        anOutIrq;

   int checks = 0;
   int errors = 0;

   mirage_gpio_bank dut (
      .aClock         (aClock),
      .aReset         (aReset),
      .aAddress       (aAddress),
      .aWriteData     (aWriteData),
      .aWrite         (aWrite),
      .aRead          (aRead),
      .anOutSelect    (anOutSelect),
      .anOutReadData  (anOutReadData),
      .anOutReadValid (anOutReadValid),
      .aPinIn         (aPinIn),
      .anOutPinOut    (anOutPinOut),
      .anOutPinOe     (anOutPinOe),
      .anOutIrq       (anOutIrq)
   );

   always #5 aClock = ~aClock;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   // Register-level model: plain integers per port, pin samples kept as a short history.
   int  mOut [NP];
   int  mDir [NP];
   int  mPend[NP];
   int  mIe  [NP];
   int  hist [3];
   int  mArm;
   bit  live = 1'b0;
   bit  expValid;
   bit  expIrq;
   int  expData;

   function automatic bit modelHit(input logic [15:0] a);
      int off = int'(a) - BASE;
      return (off >= 0) && (off < 8 * NP);
   endfunction

   function automatic int packPorts(input int v0, input int v1);
      return (v0 & 'hFF) | ((v1 & 'hFF) << 8);
   endfunction

   always @(posedge aClock) begin
      int off, p, r, wd, rd, inNow, prevNow;
      int riseV[NP];
      bit hitNow;
      if (aReset) begin
         for (int q = 0; q < NP; q++) begin
            mOut[q] = 0; mDir[q] = 0; mPend[q] = 0; mIe[q] = 0;
         end
         hist[0] = 0; hist[1] = 0; hist[2] = 0;
         mArm = 0; expValid = 0; expIrq = 0; expData = 0;
         live = 1'b1;
      end else if (live) begin
         off    = int'(aAddress) - BASE;
         hitNow = modelHit(aAddress);
         p      = hitNow ? off / 8 : 0;
         r      = hitNow ? off % 8 : 0;
         wd     = int'(aWriteData) & 'hFF;

         rd = 0;
         if (hitNow && aRead) begin
            case (r)
               0: rd = mOut[p];
               1: rd = mDir[p];
               2: rd = (hist[1] >> (8 * p)) & 'hFF;
               3: rd = mPend[p];
               4: rd = mIe[p];
               default: rd = 0;
            endcase
         end
         expValid = hitNow && aRead;
         expData  = rd;

         expIrq = 0;
         for (int q = 0; q < NP; q++) begin
            if ((mPend[q] & mIe[q]) != 0) expIrq = 1;
            inNow    = (hist[1] >> (8 * q)) & 'hFF;
            prevNow  = (hist[2] >> (8 * q)) & 'hFF;
            riseV[q] = (mArm == 3) ? (inNow & ~prevNow & ~mDir[q] & 'hFF) : 0;
         end

         if (hitNow && aWrite) begin
            case (r)
               0: mOut[p]  = wd;
               1: mDir[p]  = wd;
               3: mPend[p] = mPend[p] & ~wd;
               4: mIe[p]   = wd;
               5: mOut[p]  = mOut[p] | wd;
               6: mOut[p]  = mOut[p] & ~wd & 'hFF;
               7: mOut[p]  = mOut[p] ^ wd;
               default: ;
            endcase
         end
         for (int q = 0; q < NP; q++) mPend[q] = mPend[q] | riseV[q];

         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = int'(aPinIn);
         if (mArm < 3) mArm++;
      end
   end

   // Single compare process: every cycle once the model has seen a reset.
   always @(negedge aClock) begin
      if (live) begin
         check("readValid", {31'b0, anOutReadValid}, {31'b0, expValid});
         check("readData", {16'b0, anOutReadData}, expData);
         check("irq", {31'b0, anOutIrq}, {31'b0, expIrq});
         check("pinOut", {16'b0, anOutPinOut}, packPorts(mOut[0], mOut[1]));
         check("pinOe", {16'b0, anOutPinOe}, packPorts(mDir[0], mDir[1]));
         check("select", {31'b0, anOutSelect}, {31'b0, modelHit(aAddress)});
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge aClock);
         #1;
      end
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] data);
      aRead = rd; aWrite = wr; aAddress = addr; aWriteData = data;
      @(posedge aClock);
      #1;
      aRead = 1'b0; aWrite = 1'b0;
   endtask

   task automatic busWrite(input logic [15:0] addr, input logic [15:0] data);
      drive(1'b0, 1'b1, addr, data);
   endtask

   task automatic readExpect(input string name, input logic [15:0] addr, input logic [15:0] expected);
      drive(1'b1, 1'b0, addr, 16'h0);
      check({name, ".valid"}, {31'b0, anOutReadValid}, 32'd1);
      check(name, {16'b0, anOutReadData}, {16'b0, expected});
   endtask

   initial begin
      logic [7:0] low;
      idle(3);
      aReset = 1'b0;

      check("reset.readValid", {31'b0, anOutReadValid}, 32'd0);
      check("reset.irq", {31'b0, anOutIrq}, 32'd0);
      check("reset.pinOut", {16'b0, anOutPinOut}, 32'd0);
      for (int p = 0; p < NP; p++) begin
         readExpect("reset.OUT",  16'(BASE + 8 * p + 0), 16'h0);
         readExpect("reset.DIR",  16'(BASE + 8 * p + 1), 16'h0);
         readExpect("reset.PEND", 16'(BASE + 8 * p + 3), 16'h0);
         readExpect("reset.IE",   16'(BASE + 8 * p + 4), 16'h0);
      end

      busWrite(16'h0200, 16'h00A5);
      low = anOutPinOut[7:0];
      check("out.write", {24'b0, low}, 32'hA5);
      busWrite(16'h0205, 16'h000F);
      low = anOutPinOut[7:0];
      check("out.set", {24'b0, low}, 32'hAF);
      busWrite(16'h0206, 16'h0001);
      low = anOutPinOut[7:0];
      check("out.clr", {24'b0, low}, 32'hAE);
      busWrite(16'h0207, 16'h00FF);
      low = anOutPinOut[7:0];
      check("out.tgl", {24'b0, low}, 32'h51);
      readExpect("out.readback", 16'h0200, 16'h0051);

      busWrite(16'h0209, 16'h0000);
      busWrite(16'h020C, 16'h0001);
      aPinIn[8] = 1'b1;
      idle(4);
      readExpect("in.port1", 16'h020A, 16'h0001);
      readExpect("pend.port1", 16'h020B, 16'h0001);
      check("irq.high", {31'b0, anOutIrq}, 32'd1);

      busWrite(16'h020B, 16'h0001);
      aPinIn[8] = 1'b0;
      idle(3);
      readExpect("pend.cleared", 16'h020B, 16'h0000);
      aPinIn[8] = 1'b1;
      idle(2);
      busWrite(16'h020B, 16'h0001);
      readExpect("pend.setWins", 16'h020B, 16'h0001);
      check("irq.stillHigh", {31'b0, anOutIrq}, 32'd1);
      busWrite(16'h020B, 16'h0001);
      readExpect("pend.finalClear", 16'h020B, 16'h0000);
      check("irq.low", {31'b0, anOutIrq}, 32'd0);

      aPinIn[0] = 1'b1;
      aReset = 1'b1;
      idle(2);
      aReset = 1'b0;
      idle(6);
      readExpect("arm.port0", 16'h0203, 16'h0000);
      readExpect("arm.port1", 16'h020B, 16'h0000);
      busWrite(16'h0201, 16'h0001);
      repeat (3) begin
         aPinIn[0] = 1'b0;
         idle(4);
         aPinIn[0] = 1'b1;
         idle(4);
      end
      readExpect("dirMask.pend", 16'h0203, 16'h0000);
      low = anOutPinOe[7:0];
      check("dirMask.pinOe", {24'b0, low}, 32'h01);

      aAddress = 16'h0210; aRead = 1'b1;
      #1;
      check("span.select", {31'b0, anOutSelect}, 32'd0);
      @(posedge aClock);
      #1;
      aRead = 1'b0;
      check("span.readValid", {31'b0, anOutReadValid}, 32'd0);
      aAddress = 16'h020F;
      #1;
      check("span.lastSelect", {31'b0, anOutSelect}, 32'd1);
      busWrite(16'h0200, 16'h003C);
      drive(1'b1, 1'b1, 16'h0200, 16'h00C3);
      check("rw.readValid", {31'b0, anOutReadValid}, 32'd1);
      check("rw.oldData", {16'b0, anOutReadData}, 32'h3C);
      low = anOutPinOut[7:0];
      check("rw.newOut", {24'b0, low}, 32'hC3);

      for (int i = 0; i < 4000; i++) begin
         aReset     = ($urandom_range(0, 199) == 0);
         aRead      = $urandom_range(0, 1);
         aWrite     = $urandom_range(0, 1);
         aWriteData = 16'($urandom);
         if ($urandom_range(0, 7) == 0) aAddress = 16'($urandom);
         else aAddress = 16'(BASE + $urandom_range(0, 17));
         if ($urandom_range(0, 3) == 0) aPinIn = aPinIn ^ (16'h1 << $urandom_range(0, 15));
         @(posedge aClock);
         #1;
      end
      aReset = 1'b0; aRead = 1'b0; aWrite = 1'b0;
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
